fetch_unit: RTL and testbench

Instruction fetch stage for the out-of-order core. Generates the PC stream, issues one instruction-memory read at a time, and pushes {pc, inst} packets into the instruction queue directly downstream. Handles queue back-pressure with a one-entry hold register, and handles branch/exception redirects by squashing in-flight responses.

---
 rtl/rv32i_types.sv | 19 +
 rtl/fetch_perf_ctr.sv | 17 +
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the fetch stage: FSM state encoding and the queue packet layout.
package rv32i_types;

  localparam logic [31:0] DEF_RESET_PC  = 32'h1eceb000;
  localparam int          DEF_PKT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating 32-bit event counter with increment enable; clears on async reset.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, one-entry hold on queue full, redirect squash.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state   | meaning
// IDLE    | nothing in flight; issue at pc unless redirected
// WAIT    | request at pc in flight; accept response
// HOLD    | response captured in hold_inst, queue full
// DISCARD | stale request in flight; drop its response, then reissue at pc
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          PKT_WIDTH = DEF_PKT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          imem_addr,
  output logic [3:0]           imem_rmask,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_resp,
  input  logic                 redirect_in,
  input  logic [31:0]          redirect_pc,
  output logic [PKT_WIDTH-1:0] wdata_out,
  output logic                 enqueue_out,
  input  logic                 full_in,
  output logic [31:0]          perf_fetched_out,
  output logic [31:0]          perf_stall_out
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_inc;
  logic [31:0]  hold_inst, hold_next;
  fetch_pkt_t   pkt;

  assign pc_inc = pc + 32'd4;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    hold_next   = hold_inst;
    imem_rmask  = 4'h0;
    imem_addr   = pc;
    enqueue_out = 1'b0;
    pkt         = '0;
    if (redirect_in) begin
      pc_next    = redirect_pc;
      // an unanswered request must still be drained before reissuing
      state_next = ((state == WAIT || state == DISCARD) && !imem_resp) ? DISCARD : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rst) begin
            imem_rmask = 4'hF;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            if (!full_in) begin
              enqueue_out = 1'b1;
              pkt         = '{pc: pc, inst: imem_rdata};
              pc_next     = pc_inc;
              imem_rmask  = 4'hF;
              imem_addr   = pc_inc;
            end else begin
              hold_next  = imem_rdata;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (!full_in) begin
            enqueue_out = 1'b1;
            pkt         = '{pc: pc, inst: hold_inst};
            pc_next     = pc_inc;
            imem_rmask  = 4'hF;
            imem_addr   = pc_inc;
            state_next  = WAIT;
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            imem_rmask = 4'hF;
            state_next = WAIT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign wdata_out = PKT_WIDTH'(pkt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      hold_inst <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      hold_inst <= hold_next;
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_cycle;
  assign stall_cycle = (state == HOLD) && full_in;

  fetch_perf_ctr u_perf_fetched (
    .clk   (clk),
    .rst   (rst),
    .inc   (enqueue_out),
    .count (perf_fetched_out)
  );

  fetch_perf_ctr u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_cycle),
    .count (perf_stall_out)
  );
`else
  assign perf_fetched_out = '0;
  assign perf_stall_out   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_in;
  logic [31:0] redirect_pc;
  logic [63:0] wdata_out;
  logic        enqueue_out;
  logic        full_in;
  logic [31:0] perf_fetched_out;
  logic [31:0] perf_stall_out;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_rmask       (imem_rmask),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .redirect_in      (redirect_in),
    .redirect_pc      (redirect_pc),
    .wdata_out        (wdata_out),
    .enqueue_out      (enqueue_out),
    .full_in          (full_in),
    .perf_fetched_out (perf_fetched_out),
    .perf_stall_out   (perf_stall_out)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1eceb008) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  // memory model: one pending request, latency in cycles
  logic        mem_pend, mem_stale;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_mode;
  // reference model: next pc to be enqueued, whether a packet is parked
  logic [31:0] exp_pc;
  logic        held;
  int          n_enq, n_stall;
  // stimulus knobs
  logic        full_q, redir_q;
  logic [31:0] rpc_q, hold_addr;
  int          hold_left;
  logic        redir_on_resp;
  logic [31:0] redir_on_resp_pc;
  logic        req_seen;
  logic [31:0] enq_pcs[$];

  function automatic logic [31:0] q_at(input int i);
    if (enq_pcs.size() > i) return enq_pcs[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic cycle();
    logic fresh, exp_enq, hold_persist, outstanding, exp_rmask;
    logic [31:0] exp_addr;
    if (mem_pend && mem_cnt > 0) mem_cnt--;
    imem_resp   = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_resp ? mem_fn(mem_addr) : $urandom();
    full_in     = full_q;
    redirect_in = redir_q;
    redirect_pc = rpc_q;
    if (imem_resp && !mem_stale && mem_addr == hold_addr) hold_left = 4;
    if (hold_left > 0) begin
      full_in = 1'b1;
      hold_left--;
    end
    if (redir_on_resp && imem_resp) begin
      redirect_in   = 1'b1;
      redirect_pc   = redir_on_resp_pc;
      redir_on_resp = 1'b0;
    end
    @(negedge clk);
    fresh = imem_resp && !mem_stale;
    if (rst) begin
      chk("rst_enqueue", enqueue_out, 64'd0);
      chk("rst_rmask", imem_rmask, 64'd0);
      chk("rst_wdata", wdata_out, 64'd0);
      chk("rst_perf_fetched", perf_fetched_out, 64'd0);
      chk("rst_perf_stall", perf_stall_out, 64'd0);
      held   = 1'b0;
      exp_pc = RST_PC;
      n_enq  = 0;
      n_stall = 0;
      if (imem_resp) mem_pend = 1'b0;
      if (mem_pend) mem_stale = 1'b1;
    end else begin
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched_out, 64'(n_enq));
      chk("perf_stall", perf_stall_out, 64'(n_stall));
`else
      chk("perf_fetched_off", perf_fetched_out, 64'd0);
      chk("perf_stall_off", perf_stall_out, 64'd0);
`endif
      exp_enq      = !redirect_in && !full_in && (fresh || held);
      hold_persist = !redirect_in && full_in && (fresh || held);
      outstanding  = mem_pend && !imem_resp;
      exp_rmask    = !redirect_in && !outstanding && !hold_persist;
      exp_addr     = exp_enq ? exp_pc + 32'd4 : exp_pc;
      chk("enqueue", enqueue_out, exp_enq);
      if (exp_enq) chk("packet", wdata_out, {exp_pc, mem_fn(exp_pc)});
      chk("rmask", imem_rmask, exp_rmask ? 64'hF : 64'h0);
      if (exp_rmask) chk("addr", imem_addr, exp_addr);
      if (held && full_in) n_stall++;
      if (exp_enq) begin
        enq_pcs.push_back(exp_pc);
        n_enq++;
        exp_pc = exp_pc + 32'd4;
        held   = 1'b0;
      end
      if (hold_persist) held = 1'b1;
      if (redirect_in) begin
        exp_pc = redirect_pc;
        held   = 1'b0;
      end
      if (imem_resp) mem_pend = 1'b0;
      if (redirect_in && mem_pend) mem_stale = 1'b1;
    end
    if (!rst && imem_rmask != 4'h0) begin
      mem_pend  = 1'b1;
      mem_stale = 1'b0;
      mem_addr  = imem_addr;
      mem_cnt   = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      req_seen  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    full_q = 1'b0; redir_q = 1'b0; rpc_q = '0;
    hold_addr = 32'h3; hold_left = 0;
    redir_on_resp = 1'b0; redir_on_resp_pc = '0;
    lat_mode = 1; mem_pend = 1'b0; mem_stale = 1'b0; mem_cnt = 0; mem_addr = '0;
    held = 1'b0; exp_pc = RST_PC; n_enq = 0; n_stall = 0; req_seen = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; full_in = 1'b0; redirect_in = 1'b0; redirect_pc = '0;
    #1;
    repeat (3) cycle();
    rst = 1'b0;

    // latency 1 stream, queue full for 4 cycles when 0x1eceb008 returns
    hold_addr = 32'h1eceb008;
    repeat (12) cycle();
    hold_addr = 32'h3;
    chk("stream_pc0", q_at(0), 64'h1eceb000);
    chk("hold_pc", q_at(2), 64'h1eceb008);
`ifdef FETCH_PERF_EN
    chk("stall_count", perf_stall_out, 64'd3);
`endif

    // redirect one cycle after a latency-4 request
    lat_mode = 4; req_seen = 1'b0;
    for (int i = 0; i < 10 && !req_seen; i++) cycle();
    enq_pcs.delete();
    redir_q = 1'b1; rpc_q = 32'h1eceb100;
    cycle();
    redir_q = 1'b0;
    repeat (8) cycle();
    chk("redir_first", q_at(0), 64'h1eceb100);

    // redirect coinciding with a response
    lat_mode = 2; enq_pcs.delete();
    redir_on_resp = 1'b1; redir_on_resp_pc = 32'h1eceb200;
    repeat (10) cycle();
    chk("same_cyc_first", q_at(0), 64'h1eceb200);

    // wrap from the top of the address space
    lat_mode = 1; enq_pcs.delete();
    redir_on_resp = 1'b1; redir_on_resp_pc = 32'hFFFF_FFFC;
    repeat (8) cycle();
    chk("wrap_pc0", q_at(0), 64'hFFFF_FFFC);
    chk("wrap_pc1", q_at(1), 64'h0);

    // reset while a latency-4 request is in flight
    lat_mode = 4; req_seen = 1'b0;
    for (int i = 0; i < 10 && !req_seen; i++) cycle();
    rst = 1'b1;
    repeat (6) cycle();
    rst = 1'b0;
    enq_pcs.delete();
    repeat (8) cycle();
    chk("rst_restart", q_at(0), 64'(RST_PC));

    // random traffic
    lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      full_q  = ($urandom_range(0, 3) == 0);
      redir_q = ($urandom_range(0, 24) == 0);
      rpc_q   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      cycle();
    end
    full_q = 1'b0; redir_q = 1'b0;
    repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
